// File: rtl/serial_sub32.sv
// Digit-serial subtractor: X = A - B - bin, one DIGIT-bit borrow stage reused
// over WIDTH/DIGIT cycles, with a start/done handshake toward the sequencer.
module serial_sub32 #(
   parameter int WIDTH = 32,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] x,
   output logic             bout,
   output logic             ovf,
   output logic [1:0]       dbg_state
);

   // Handshake: start is sampled on a rising edge only in IDLE or DONE; that
   // edge captures a/b/bin. done is high for exactly one cycle, during which
   // x/bout/ovf hold the new result; start high in that cycle chains the next op.

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   generate
      if ((DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_bad_digit
         $error("serial_sub32: DIGIT must be >= 1 and divide WIDTH");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_next;
   logic                 w_accept;
   logic                 w_last;
   logic [CW-1:0]        r_cnt;
   logic [WIDTH-1:0]     r_a;
   logic [WIDTH-1:0]     r_b;
   logic                 r_brw;
   logic                 r_a_msb;
   logic                 r_b_msb;
   logic [WIDTH-1:0]     r_acc;
   logic [WIDTH-1:0]     r_x;
   logic                 r_bout;
   logic                 r_ovf;
   logic [DIGIT:0]       w_diff;
   logic [WIDTH+DIGIT-1:0] w_cat;
   logic [WIDTH-1:0]     w_acc_next;
   logic                 w_ovf;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      w_last   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_accept = 1'b1;
               w_next   = S_RUN;
            end
         end
         S_RUN: begin
            if (r_cnt == CNT_LAST) begin
               w_last = 1'b1;
               w_next = S_DONE;
            end
         end
         S_DONE: begin
            if (start) begin
               w_accept = 1'b1;
               w_next   = S_RUN;
            end else begin
               w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Operands shift right so the current digit always sits in the low bits;
   // the one-bit extension of the difference carries out the new borrow.
   assign w_diff = {1'b0, r_a[DIGIT-1:0]} - {1'b0, r_b[DIGIT-1:0]}
                 - {{DIGIT{1'b0}}, r_brw};
   assign w_cat      = {w_diff[DIGIT-1:0], r_acc};
   assign w_acc_next = w_cat[WIDTH+DIGIT-1:DIGIT];
   assign w_ovf      = (r_a_msb != r_b_msb) && (w_acc_next[WIDTH-1] != r_a_msb);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt   <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_brw   <= 1'b0;
         r_a_msb <= 1'b0;
         r_b_msb <= 1'b0;
         r_acc   <= '0;
         r_x     <= '0;
         r_bout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else if (w_accept) begin
         r_cnt   <= '0;
         r_a     <= a;
         r_b     <= b;
         r_brw   <= bin;
         r_a_msb <= a[WIDTH-1];
         r_b_msb <= b[WIDTH-1];
         r_acc   <= '0;
      end else if (r_state == S_RUN) begin
         r_cnt <= r_cnt + CNT_ONE;
         r_a   <= r_a >> DIGIT;
         r_b   <= r_b >> DIGIT;
         r_brw <= w_diff[DIGIT];
         r_acc <= w_acc_next;
         // Results are published only once the top digit is in.
         if (w_last) begin
            r_x    <= w_acc_next;
            r_bout <= w_diff[DIGIT];
            r_ovf  <= w_ovf;
         end
      end
   end

   assign busy      = (r_state == S_RUN);
   assign done      = (r_state == S_DONE);
   assign x         = r_x;
   assign bout      = r_bout;
   assign ovf       = r_ovf;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_serial_sub32.sv
// Randomised and directed bench for serial_sub32, scored against an
// arithmetic reference model (a - b - bin at 33 bits, signed range test).
module tb_serial_sub32;

   localparam int W  = 32;
   localparam int N  = 8;
   localparam int EW = W + 2;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [W-1:0]  a_i;
   logic [W-1:0]  b_i;
   logic          bin_i;
   logic          busy;
   logic          done;
   logic [W-1:0]  x;
   logic          bout;
   logic          ovf;
   logic [1:0]    dbg_state;

   int            n_checks = 0;
   int            n_errors = 0;
   logic [EW-1:0] exp_q[$];
   logic [EW-1:0] prev_exp;
   logic [EW-1:0] cur_exp;
   logic [EW-1:0] mon_e;
   logic          prev_done;

   serial_sub32 #(.WIDTH(W), .DIGIT(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .a         (a_i),
      .b         (b_i),
      .bin       (bin_i),
      .busy      (busy),
      .done      (done),
      .x         (x),
      .bout      (bout),
      .ovf       (ovf),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset / watchdog ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- checking and model ----------------
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // {ovf, bout, x}
   function automatic logic [EW-1:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                           input logic cv);
      logic [W:0] d;
      longint     sd;
      logic       o;
      d  = {1'b0, av} - {1'b0, bv} - {{W{1'b0}}, cv};
      sd = longint'($signed(av)) - longint'($signed(bv)) - longint'(cv);
      o  = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
      return {o, d[W], d[W-1:0]};
   endfunction

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_done = 1'b0;
      end else begin
         if (done) begin
            check("done_width", prev_done, 0);
            check("busy_at_done", busy, 0);
            if (exp_q.size() == 0) begin
               check("unexpected_done", done, 0);
            end else begin
               mon_e = exp_q.pop_front();
               check("x", x, mon_e[W-1:0]);
               check("bout", bout, mon_e[W]);
               check("ovf", ovf, mon_e[W+1]);
            end
         end
         prev_done = done;
      end
   end

   // ---------------- driver tasks ----------------
   // Called at a negedge with the DUT in IDLE or DONE.
   task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
      a_i      = av;
      b_i      = bv;
      bin_i    = cv;
      start    = 1'b1;
      prev_exp = cur_exp;
      cur_exp  = model(av, bv, cv);
      exp_q.push_back(cur_exp);
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Returns at the negedge where done is seen; lat counts negedges before it.
   task automatic wait_done(output int lat, output int bcnt, input bit scramble);
      lat  = -1;
      bcnt = 0;
      for (int c = 0; c < 3 * N; c++) begin
         @(negedge clk);
         if (done) begin
            lat   = c;
            start = 1'b0;
            break;
         end
         if (busy) bcnt++;
         if (c == 3) check("x_hold", {ovf, bout, x}, prev_exp);
         if (scramble) begin
            start = 1'($urandom_range(0, 1));
            a_i   = $urandom;
            b_i   = $urandom;
            bin_i = 1'($urandom_range(0, 1));
         end
      end
      check("done_seen", (lat >= 0), 1);
   endtask

   // ---------------- stimulus ----------------
   logic [W-1:0] ta [5];
   logic [W-1:0] tb [5];
   logic         tc [5];
   logic [W-1:0] tx [5];
   logic         tbo[5];
   logic         tov[5];

   initial begin
      int lat;
      int bcnt;
      int c4;
      logic [W-1:0] ra;
      logic [W-1:0] rb;

      ta[0] = 32'h2;        tb[0] = 32'h1;        tc[0] = 1'b1; tx[0] = 32'h0;        tbo[0] = 1'b0; tov[0] = 1'b0;
      ta[1] = 32'h1;        tb[1] = 32'h2;        tc[1] = 1'b0; tx[1] = 32'hFFFFFFFF; tbo[1] = 1'b1; tov[1] = 1'b0;
      ta[2] = 32'h87654321; tb[2] = 32'h12345678; tc[2] = 1'b0; tx[2] = 32'h7530ECA9; tbo[2] = 1'b0; tov[2] = 1'b1;
      ta[3] = 32'h80000000; tb[3] = 32'h1;        tc[3] = 1'b0; tx[3] = 32'h7FFFFFFF; tbo[3] = 1'b0; tov[3] = 1'b1;
      ta[4] = 32'h5A5A5A5A; tb[4] = 32'h5A5A5A5A; tc[4] = 1'b1; tx[4] = 32'hFFFFFFFF; tbo[4] = 1'b1; tov[4] = 1'b0;

      start    = 1'b0;
      a_i      = '0;
      b_i      = '0;
      bin_i    = 1'b0;
      prev_exp = '0;
      cur_exp  = '0;
      rst_n    = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_x", x, 0);
      check("rst_bout", bout, 0);
      check("rst_ovf", ovf, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed operands with known answers.
      for (int i = 0; i < 5; i++) begin
         issue(ta[i], tb[i], tc[i]);
         wait_done(lat, bcnt, 1'b0);
         check("latency", lat, N);
         check("busy_cycles", bcnt, N);
         check("dir_x", x, tx[i]);
         check("dir_bout", bout, tbo[i]);
         check("dir_ovf", ovf, tov[i]);
         @(negedge clk);
      end

      // Back-to-back with start held high across done; mid-run input noise.
      issue(32'h00001234, 32'h00000034, 1'b0);
      c4 = -1;
      for (int c = 0; c < 3 * N; c++) begin
         @(negedge clk);
         if (done) begin
            c4 = c;
            break;
         end
         if (c == 2) begin
            start = 1'b1;
            a_i   = $urandom;
         end
      end
      check("b2b_first_latency", c4, N);
      check("b2b_first_x", x, 32'h00001200);
      a_i      = 32'h0A;
      b_i      = 32'h20;
      bin_i    = 1'b0;
      prev_exp = cur_exp;
      cur_exp  = model(32'h0A, 32'h20, 1'b0);
      exp_q.push_back(cur_exp);
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(lat, bcnt, 1'b1);
      check("b2b_gap", lat, N);
      check("b2b_x", x, 32'hFFFFFFEA);
      check("b2b_bout", bout, 1);
      @(negedge clk);

      // Asynchronous reset three cycles into a run.
      issue(32'h0000FFFF, 32'h00000001, 1'b0);
      repeat (3) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_busy", busy, 0);
      check("arst_done", done, 0);
      check("arst_x", x, 0);
      check("arst_bout", bout, 0);
      check("arst_ovf", ovf, 0);
      exp_q.delete();
      prev_exp = '0;
      cur_exp  = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         check("no_done_after_rst", done, 0);
      end
      issue(32'h00000100, 32'h00000001, 1'b1);
      wait_done(lat, bcnt, 1'b0);
      check("post_rst_latency", lat, N);
      check("post_rst_x", x, 32'h000000FE);

      // Randomised operations, mixing idle gaps and back-to-back issue.
      for (int i = 0; i < 1000; i++) begin
         case ($urandom_range(0, 5))
            0: begin ra = $urandom; rb = ra; end
            1: begin ra = '0; rb = $urandom; end
            2: begin ra = {1'b1, 31'($urandom)}; rb = {1'b0, 31'($urandom)}; end
            default: begin ra = $urandom; rb = $urandom; end
         endcase
         issue(ra, rb, 1'($urandom_range(0, 1)));
         wait_done(lat, bcnt, 1'($urandom_range(0, 1)));
         check("rand_latency", lat, N);
         if ($urandom_range(0, 1) == 1) @(negedge clk);
      end

      repeat (2) @(negedge clk);
      check("queue_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
